// File: rtl/npc_defs_pkg.sv
// Shared definitions for the NPC program-counter / fetch slice.
package npc_defs;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } npc_state_e;

  localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;

  // {PCAsrc, PCBsrc} pairs driven by the branch-condition unit.
  localparam logic [1:0] SEL_SNPC  = 2'b01;
  localparam logic [1:0] SEL_PCREL = 2'b11;
  localparam logic [1:0] SEL_JALR  = 2'b10;

endpackage

// File: rtl/npc_next_pc.sv
// Next-PC datapath: operand muxes, 32-bit wrapping adder, bit0 clear and
// misalignment flag. Purely combinational so it can be shared with the
// difftest model wrapper.
module npc_next_pc (
  input  logic        a_sel_imm,
  input  logic        b_sel_pc,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic [31:0] target,
  output logic        misalign
);

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] sum;

  // Select operands, add, clear bit0 and flag a halfword-aligned target.
  always_comb begin
    op_a     = a_sel_imm ? imm : 32'd4;
    op_b     = b_sel_pc  ? pc  : rs1;
    sum      = op_a + op_b;
    target   = {sum[31:1], 1'b0};
    misalign = target[1];
  end

endmodule

// File: rtl/npc_pc_fetch.sv
// PC register, instruction register and fetch/commit sequencer.
module npc_pc_fetch
  import npc_defs::*;
#(
  parameter logic [31:0] RESET_PC = NPC_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCAsrc,
  input  logic        PCBsrc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  input  logic        commit,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        fault
);

  npc_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] target;
  logic        misalign;

  npc_next_pc u_next_pc (
    .a_sel_imm (PCAsrc),
    .b_sel_pc  (PCBsrc),
    .pc        (pc_q),
    .imm       (imm),
    .rs1       (rs1),
    .target    (target),
    .misalign  (misalign)
  );

  // Next-state, PC and instruction-register update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    unique case (state_q)
      ST_FETCH: if (imem_req_ready) state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            state_d = ST_HALT;
          end else begin
            inst_d  = imem_rsp_data;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (commit) begin
          if (misalign) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = target;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  // Outputs decoded from registered state only; rst suppresses the request.
  always_comb begin
    pc             = pc_q;
    imem_req_addr  = pc_q;
    inst           = inst_q;
    imem_req_valid = (state_q == ST_FETCH) && !rst;
    inst_valid     = (state_q == ST_EXEC);
    fault          = (state_q == ST_HALT);
  end

endmodule

// File: tb/tb_npc_pc_fetch.sv
// Bench for npc_pc_fetch: directed scenarios followed by randomized
// instruction streams checked against a transaction-level PC model.
module tb_npc_pc_fetch;
  import npc_defs::*;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk, rst;
  logic        PCAsrc, PCBsrc, commit;
  logic [31:0] imm, rs1;
  logic [31:0] pc, inst;
  logic        inst_valid;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_rsp_data;
  logic        fault;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] m_pc;
  logic        halted;

  npc_pc_fetch #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .PCAsrc         (PCAsrc),
    .PCBsrc         (PCBsrc),
    .imm            (imm),
    .rs1            (rs1),
    .commit         (commit),
    .pc             (pc),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    commit = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_err = 1'b0; imem_rsp_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    #1;
    check("rst_reqv", {31'd0, imem_req_valid}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    m_pc   = RPC;
    halted = 1'b0;
    check("rst_pc",    pc,                       RPC);
    check("rst_inst",  inst,                     32'd0);
    check("rst_ivld",  {31'd0, inst_valid},      32'd0);
    check("rst_fault", {31'd0, fault},           32'd0);
    check("rst_reqv1", {31'd0, imem_req_valid},  32'd1);
    check("rst_addr",  imem_req_addr,            RPC);
  endtask

  // Halted core: nothing provokes activity, pc frozen.
  task automatic check_halt(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      commit = $urandom_range(0, 1);
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_err = 1'b0;
      imem_rsp_data = $urandom;
      #1;
      check("halt_fault", {31'd0, fault},          32'd1);
      check("halt_reqv",  {31'd0, imem_req_valid}, 32'd0);
      check("halt_ivld",  {31'd0, inst_valid},     32'd0);
      check("halt_pc",    pc,                      m_pc);
      step();
    end
    idle_inputs();
  endtask

  // One full instruction; entered and left one tick after an edge.
  task automatic do_instr(input int unsigned req_stall, input int unsigned rsp_delay,
                          input int unsigned commit_delay, input logic [31:0] data,
                          input logic err, input logic [1:0] sel,
                          input logic [31:0] i_imm, input logic [31:0] i_rs1,
                          input logic junk);
    logic [31:0] a, b, t;
    for (int unsigned i = 0; i < req_stall; i++) begin
      imem_req_ready = 1'b0;
      #1;
      check("stall_reqv", {31'd0, imem_req_valid}, 32'd1);
      check("stall_addr", imem_req_addr, m_pc);
      check("stall_ivld", {31'd0, inst_valid}, 32'd0);
      step();
    end
    imem_req_ready = 1'b1;
    imem_rsp_valid = junk;
    imem_rsp_err = 1'b1;
    #1;
    check("req_reqv", {31'd0, imem_req_valid}, 32'd1);
    check("req_addr", imem_req_addr, m_pc);
    step();
    imem_req_ready = $urandom_range(0, 1);
    imem_rsp_valid = 1'b0;
    imem_rsp_err = 1'b0;
    for (int unsigned i = 0; i < rsp_delay; i++) begin
      commit = junk;
      #1;
      check("wait_reqv", {31'd0, imem_req_valid}, 32'd0);
      check("wait_ivld", {31'd0, inst_valid}, 32'd0);
      check("wait_pc", pc, m_pc);
      step();
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_err = err;
    imem_rsp_data = data;
    commit = junk;
    #1;
    check("rsp_reqv", {31'd0, imem_req_valid}, 32'd0);
    step();
    idle_inputs();
    if (err) begin
      halted = 1'b1;
      check_halt(3);
      return;
    end
    for (int unsigned i = 0; i <= commit_delay; i++) begin
      PCAsrc = sel[1];
      PCBsrc = sel[0];
      imm = i_imm;
      rs1 = i_rs1;
      commit = (i == commit_delay);
      imem_rsp_valid = junk;
      imem_rsp_err = 1'b1;
      #1;
      check("exec_ivld", {31'd0, inst_valid}, 32'd1);
      check("exec_inst", inst, data);
      check("exec_pc", pc, m_pc);
      check("exec_reqv", {31'd0, imem_req_valid}, 32'd0);
      check("exec_fault", {31'd0, fault}, 32'd0);
      step();
    end
    idle_inputs();
    a = sel[1] ? i_imm : 32'd4;
    b = sel[0] ? m_pc : i_rs1;
    t = a + b;
    t = t - (t % 2);
    if ((t % 4) != 0) begin
      halted = 1'b1;
      check_halt(3);
    end else begin
      m_pc = t;
      #1;
      check("next_reqv", {31'd0, imem_req_valid}, 32'd1);
      check("next_addr", imem_req_addr, t);
    end
  endtask

  initial begin
    rst = 1'b1;
    PCAsrc = 1'b0; PCBsrc = 1'b1; imm = '0; rs1 = '0;
    idle_inputs();
    m_pc = RPC;
    halted = 1'b0;
    step();
    do_reset();

    // Basic sequential flow, reach pc = 0x8000_0010.
    do_instr(0, 0, 0, 32'h0000_0013, 1'b0, SEL_SNPC, 32'd0, 32'd0, 1'b0);
    check("seq_pc4", imem_req_addr, 32'h8000_0004);
    for (int unsigned i = 0; i < 3; i++)
      do_instr(0, 0, 0, 32'h0000_0013, 1'b0, SEL_SNPC, 32'd0, 32'd0, 1'b0);
    check("pc_0x10", pc, 32'h8000_0010);
    do_instr(0, 0, 0, 32'h0000_006f, 1'b0, SEL_PCREL, 32'hFFFF_FFF8, 32'd0, 1'b0);
    check("pcrel_back", imem_req_addr, 32'h8000_0008);
    do_instr(0, 0, 0, 32'h0000_0067, 1'b0, SEL_JALR, 32'h0000_0003, 32'h8000_0101, 1'b0);
    check("jalr_tgt", imem_req_addr, 32'h8000_0104);
    check("jalr_nofault", {31'd0, fault}, 32'd0);
    do_instr(0, 0, 0, 32'h0000_006f, 1'b0, SEL_PCREL, 32'h0000_0002, 32'd0, 1'b0);
    check("misalign_pc", pc, 32'h8000_0104);

    // Stalled request, delayed response, commit pulses in WAIT.
    do_reset();
    do_instr(5, 4, 2, 32'h1234_5678, 1'b0, SEL_SNPC, 32'd0, 32'd0, 1'b1);
    check("stall_next", imem_req_addr, 32'h8000_0004);

    // Fetch error halts.
    do_instr(1, 1, 0, 32'hDEAD_BEEF, 1'b1, SEL_SNPC, 32'd0, 32'd0, 1'b0);

    // Reset mid-WAIT; a late response in FETCH is ignored.
    do_reset();
    do_instr(0, 0, 0, 32'h0000_0013, 1'b0, SEL_SNPC, 32'd0, 32'd0, 1'b0);
    imem_req_ready = 1'b1;
    #1;
    step();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("midwait_rst_reqv", {31'd0, imem_req_valid}, 32'd0);
    step();
    rst = 1'b0;
    m_pc = RPC;
    imem_rsp_valid = 1'b1;
    imem_rsp_err = 1'b1;
    imem_rsp_data = 32'hBAD0_BAD0;
    #1;
    check("midwait_pc", pc, RPC);
    check("midwait_reqv", {31'd0, imem_req_valid}, 32'd1);
    step();
    idle_inputs();
    #1;
    check("late_rsp_fault", {31'd0, fault}, 32'd0);
    check("late_rsp_reqv", {31'd0, imem_req_valid}, 32'd1);
    check("late_rsp_ivld", {31'd0, inst_valid}, 32'd0);
    do_instr(0, 0, 0, 32'h0000_0013, 1'b0, SEL_SNPC, 32'd0, 32'd0, 1'b0);

    // Randomized instruction stream.
    for (int unsigned n = 0; n < 200; n++) begin
      logic [31:0] r_imm;
      if (halted) do_reset();
      case ($urandom_range(0, 3))
        0: r_imm = $urandom & 32'hFFFF_FFFE;
        1: r_imm = ($urandom_range(0, 511) * 4) - 32'd1024;
        2: r_imm = ($urandom_range(0, 511) * 4) + 32'd1;
        default: r_imm = $urandom_range(0, 255) * 4;
      endcase
      do_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom, ($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
               r_imm, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
